// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
//   MULT_WIDTH   : operand width supported by the adder8bit-based datapath
//   mult_state_t : controller states
//   product_t    : 2*MULT_WIDTH partial-product / result vector
package shift_add_mult_pkg;

    localparam int unsigned MULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    typedef logic [2*MULT_WIDTH-1:0] product_t;

endpackage

// File: rtl/adder8bit.sv
// Combinational 8-bit ripple adder used by the arithmetic datapath.
// Ports:
//   a, b : 8-bit addends
//   cin  : carry in
//   sum  : 8-bit sum
//   cout : carry out
module adder8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule

// File: rtl/shift_add_mult8.sv
// Sequential 8x8 unsigned shift-and-add multiplier built on adder8bit.
// One partial-product step per cycle; start/done handshake; product is
// registered and held until the next completion.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   start   : request, sampled only in IDLE
//   a, b    : multiplicand / multiplier, captured when start is accepted
//   busy    : high while in RUN
//   done    : one-cycle pulse when product is updated
//   product : registered a*b
// Optional build macro SHIFT_ADD_MULT_EARLY_TERM_EN: a zero operand skips RUN
// and completes with done one cycle after acceptance.
module shift_add_mult8
    import shift_add_mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // The datapath is hard-wired to adder8bit, so no other width can work.
    if (WIDTH != MULT_WIDTH) begin : g_width_check
        $error("shift_add_mult8: WIDTH must be 8");
    end

    mult_state_t      state_q;
    logic [WIDTH-1:0] mcand_q;
    product_t         p_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    product_t         p_next;

    adder8bit u_adder (
        .a    (p_q[2*WIDTH-1:WIDTH]),
        .b    (mcand_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Carry lands in the top bit, so the shift never loses precision.
    always_comb begin
        p_next = p_q;
        if (p_q[0]) begin
            p_next = {add_cout, add_sum, p_q[WIDTH-1:1]};
        end else begin
            p_next = {1'b0, p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_q <= a;
                        p_q     <= {{WIDTH{1'b0}}, b};
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy    <= 1'b1;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
                        // Zero operand: result is known, skip the step loop.
                        if (a == '0 || b == '0) begin
                            p_q     <= '0;
                            state_q <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            product <= '0;
                        end
`endif
                    end
                end
                RUN: begin
                    p_q   <= p_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= p_next;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult8.sv
module tb_shift_add_mult8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int errors = 0;
    int checks = 0;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    localparam bit EarlyTerm = 1'b1;
`else
    localparam bit EarlyTerm = 1'b0;
`endif

    shift_add_mult8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: cycle count from start-cycle to done-cycle.
    function automatic int exp_latency(input logic [7:0] x, input logic [7:0] y);
        if (EarlyTerm && (x == 8'd0 || y == 8'd0)) return 1;
        return 9;
    endfunction

    function automatic int exp_busy(input logic [7:0] x, input logic [7:0] y);
        return (exp_latency(x, y) == 1) ? 0 : 8;
    endfunction

    function automatic logic [15:0] exp_product(input logic [7:0] x, input logic [7:0] y);
        return 16'(x) * 16'(y);
    endfunction

    // Pulse start for one cycle and observe the following 12 cycles.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          output int done_cyc, output logic [15:0] prod,
                          output int busy_cnt, output int done_cnt,
                          output logic [15:0] end_prod);
        @(negedge clk);
        a = op_a;
        b = op_b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        done_cyc = -1;
        busy_cnt = 0;
        done_cnt = 0;
        prod = 16'hxxxx;
        for (int n = 1; n <= 12; n++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = n;
                    prod = product;
                end
            end
            if (n < 12) @(negedge clk);
        end
        end_prod = product;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'd0;
        b = 8'd0;
        #3;
        checks++;
        if ({busy, done, product} !== 18'd0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b product=%h expected 0 0 0000",
                     busy, done, product);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if (product !== 16'h0000) begin
                errors++;
                $display("FAIL reset_idle_product: got %h expected 0000", product);
            end
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_flags: done=%b busy=%b expected 0 0", done, busy);
            end
        end
    endtask

    task automatic check_op(input string name, input logic [7:0] x, input logic [7:0] y);
        int          dc, bc, dn;
        logic [15:0] p, pe;
        run_op(x, y, dc, p, bc, dn, pe);
        checks++;
        if (dc != exp_latency(x, y)) begin
            errors++;
            $display("FAIL %s_latency a=%0d b=%0d: done cycle %0d expected %0d",
                     name, x, y, dc, exp_latency(x, y));
        end
        checks++;
        if (p !== exp_product(x, y)) begin
            errors++;
            $display("FAIL %s_product a=%0d b=%0d: got %h expected %h",
                     name, x, y, p, exp_product(x, y));
        end
        checks++;
        if (bc != exp_busy(x, y)) begin
            errors++;
            $display("FAIL %s_busy a=%0d b=%0d: busy cycles %0d expected %0d",
                     name, x, y, bc, exp_busy(x, y));
        end
        checks++;
        if (dn != 1) begin
            errors++;
            $display("FAIL %s_done_pulses a=%0d b=%0d: got %0d expected 1", name, x, y, dn);
        end
        checks++;
        if (pe !== exp_product(x, y)) begin
            errors++;
            $display("FAIL %s_hold a=%0d b=%0d: got %h expected %h",
                     name, x, y, pe, exp_product(x, y));
        end
    endtask

    task automatic test_basic();
        check_op("basic", 8'd13, 8'd11);
        checks++;
        if (exp_product(8'd13, 8'd11) !== product || product !== 16'h008F) begin
            errors++;
            $display("FAIL basic_value: got %h expected 008f", product);
        end
    endtask

    task automatic test_corners();
        check_op("carry", 8'd255, 8'd255);
        check_op("pow2", 8'd128, 8'd2);
        check_op("one", 8'd1, 8'd255);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = 8'($urandom);
            if (i == 3) x = 8'd0;
            check_op("random", x, y);
        end
    endtask

    task automatic test_held_start();
        int          first, second;
        logic [15:0] p1, p2;
        first = -1;
        second = -1;
        p1 = 16'hxxxx;
        p2 = 16'hxxxx;
        @(negedge clk);
        a = 8'd3;
        b = 8'd5;
        start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                if (first < 0) begin
                    first = n;
                    p1 = product;
                end else if (second < 0) begin
                    second = n;
                    p2 = product;
                end
            end
            if (n == 4) begin
                a = 8'd7;
                b = 8'd7;
            end
        end
        start = 1'b0;
        checks++;
        if (first != 9 || p1 !== 16'h000F) begin
            errors++;
            $display("FAIL held_first: cycle %0d product %h expected cycle 9 product 000f",
                     first, p1);
        end
        checks++;
        if (second != 19 || p2 !== 16'h0031) begin
            errors++;
            $display("FAIL held_second: cycle %0d product %h expected cycle 19 product 0031",
                     second, p2);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int dn;
        @(negedge clk);
        a = 8'd200;
        b = 8'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, product} !== 18'd0) begin
            errors++;
            $display("FAIL abort_async: busy=%b done=%b product=%h expected 0 0 0000",
                     busy, done, product);
        end
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn != 0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL abort_no_done: done pulses %0d product %h expected 0 0000",
                     dn, product);
        end
        check_op("after_abort", 8'd2, 8'd3);
    endtask

    task automatic test_zero_operand();
        check_op("zero_a", 8'd0, 8'd77);
        check_op("zero_b", 8'd77, 8'd0);
        check_op("zero_ab", 8'd0, 8'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_held_start();
        test_reset_abort();
        test_zero_operand();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
